// File: rtl/pc_status_unit.sv
// Architectural PC, latched condition flags, and retired-instruction counter
// for the microcoded datapath. Feeds the status vector read by opcode decoders.
module pc_status_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Psel,
  input  logic             PCsel,
  input  logic [PC_W-1:0]  K,
  input  logic [PC_W-1:0]  data_bus,
  input  logic             SL,
  input  logic [3:0]       alu_flags,
  input  logic             alu_zero,
  input  logic             EN_PC,
  input  logic             stall,
  input  logic             commit,
  output logic [PC_W-1:0]  PC,
  output logic [PC_W-1:0]  pc_plus4,
  output logic [PC_W-1:0]  pc_bus,
  output logic             pc_bus_en,
  output logic [4:0]       status,
  output logic [CNT_W-1:0] retired,
  output logic             misalign
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic [PC_W-1:0]  r_pc;
  logic             r_v;
  logic             r_c;
  logic             r_n;
  logic             r_z;
  logic [CNT_W-1:0] r_retired;
  logic             r_misalign;

  logic [PC_W-1:0]  w_pc_plus4;
  logic [PC_W-1:0]  w_in;
  logic [PC_W-1:0]  w_pc_next;
  logic             w_pc_wr;

  always_comb begin
    w_pc_plus4 = r_pc + PC_STEP;
    w_in       = PCsel ? K : data_bus;
    w_pc_next  = r_pc;
    w_pc_wr    = 1'b0;
    case (Psel)
      2'b01: begin
        w_pc_next = w_pc_plus4;
        w_pc_wr   = 1'b1;
      end
      2'b10: begin
        w_pc_next = w_in;
        w_pc_wr   = 1'b1;
      end
      2'b11: begin
        // Word offset; the top two bits of the immediate shift out.
        w_pc_next = w_pc_plus4 + (w_in << 2);
        w_pc_wr   = 1'b1;
      end
      default: begin
        w_pc_next = r_pc;
        w_pc_wr   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_v        <= 1'b0;
      r_c        <= 1'b0;
      r_n        <= 1'b0;
      r_z        <= 1'b0;
      r_retired  <= '0;
      r_misalign <= 1'b0;
    end else if (!stall) begin
      if (w_pc_wr) begin
        r_pc <= w_pc_next;
        if (w_pc_next[1:0] != 2'b00) begin
          r_misalign <= 1'b1;
        end
      end
      // Branch decisions this cycle were made on the old flags; new ones land next cycle.
      if (SL) begin
        r_v <= alu_flags[3];
        r_c <= alu_flags[2];
        r_n <= alu_flags[1];
        r_z <= alu_flags[0];
      end
      if (commit) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign PC        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign pc_bus    = EN_PC ? w_pc_plus4 : '0;
  assign pc_bus_en = EN_PC;
  assign status    = {r_v, r_c, r_z, r_n, alu_zero};
  assign retired   = r_retired;
  assign misalign  = r_misalign;

endmodule

// File: tb/tb_pc_status_unit.sv
// Directed bench for pc_status_unit: an architectural model is checked every
// cycle, plus literal expectations for each scenario.
module tb_pc_status_unit;

  localparam int PC_W  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       Psel;
  logic             PCsel;
  logic [PC_W-1:0]  K;
  logic [PC_W-1:0]  data_bus;
  logic             SL;
  logic [3:0]       alu_flags;
  logic             alu_zero;
  logic             EN_PC;
  logic             stall;
  logic             commit;
  logic [PC_W-1:0]  PC;
  logic [PC_W-1:0]  pc_plus4;
  logic [PC_W-1:0]  pc_bus;
  logic             pc_bus_en;
  logic [4:0]       status;
  logic [CNT_W-1:0] retired;
  logic             misalign;

  pc_status_unit #(.PC_W(PC_W), .RESET_PC(64'h0), .CNT_W(CNT_W)) dut (
    .clock(clk), .reset(reset), .Psel(Psel), .PCsel(PCsel), .K(K),
    .data_bus(data_bus), .SL(SL), .alu_flags(alu_flags), .alu_zero(alu_zero),
    .EN_PC(EN_PC), .stall(stall), .commit(commit), .PC(PC), .pc_plus4(pc_plus4),
    .pc_bus(pc_bus), .pc_bus_en(pc_bus_en), .status(status), .retired(retired),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Architectural model state
  logic [63:0] m_pc;
  bit          m_v, m_c, m_z, m_n, m_mis;
  int          m_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [63:0] in_val;
    logic [63:0] npc;
    if (reset) begin
      m_pc = 64'h0; m_v = 0; m_c = 0; m_z = 0; m_n = 0; m_ret = 0; m_mis = 0;
    end else if (!stall) begin
      in_val = PCsel ? K : data_bus;
      npc = m_pc;
      case (Psel)
        2'd1: npc = m_pc + 64'd4;
        2'd2: npc = in_val;
        2'd3: npc = m_pc + 64'd4 + in_val * 64'd4;
        default: npc = m_pc;
      endcase
      if (Psel != 2'd0) begin
        m_pc = npc;
        if (npc % 64'd4 != 64'd0) m_mis = 1;
      end
      if (SL) begin
        m_v = alu_flags[3]; m_c = alu_flags[2]; m_n = alu_flags[1]; m_z = alu_flags[0];
      end
      if (commit) m_ret = (m_ret + 1) % (1 << CNT_W);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("pc", PC, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 64'd4);
      chk("pc_bus", pc_bus, EN_PC ? m_pc + 64'd4 : 64'd0);
      chk("pc_bus_en", {63'd0, pc_bus_en}, {63'd0, EN_PC});
      chk("status", {59'd0, status}, {59'd0, m_v, m_c, m_z, m_n, alu_zero});
      chk("retired", {60'd0, retired}, 64'(m_ret));
      chk("misalign", {63'd0, misalign}, {63'd0, m_mis});
    end
  end

  initial begin
    reset = 1; Psel = 0; PCsel = 0; K = 0; data_bus = 0; SL = 0; alu_flags = 0;
    alu_zero = 0; EN_PC = 0; stall = 0; commit = 0;
    cyc(); cyc();
    check_en = 1'b1;
    chk("rst_pc", PC, 64'h0);
    chk("rst_retired", {60'd0, retired}, 64'd0);
    chk("rst_flags", {60'd0, status[4:1]}, 64'd0);
    chk("rst_misalign", {63'd0, misalign}, 64'd0);
    reset = 0;

    // Sequential fetch
    Psel = 2'b01;
    cyc(); chk("seq_pc4", PC, 64'd4);
    cyc(); chk("seq_pc8", PC, 64'd8);
    cyc(); chk("seq_pc12", PC, 64'd12);
    EN_PC = 1; #1;
    chk("pc_bus_16", pc_bus, 64'd16);
    chk("pc_plus4_16", pc_plus4, 64'd16);

    // Backward relative branch
    Psel = 2'b10; PCsel = 0; data_bus = 64'h100;
    cyc(); chk("load_100", PC, 64'h100);
    Psel = 2'b11; PCsel = 1; K = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc(); chk("branch_back", PC, 64'hFC);
    chk("aligned_mis", {63'd0, misalign}, 64'd0);

    // Misaligned absolute load, sticky flag
    EN_PC = 0;
    Psel = 2'b10; PCsel = 0; data_bus = 64'h2002;
    cyc(); chk("load_2002", PC, 64'h2002);
    chk("mis_set", {63'd0, misalign}, 64'd1);
    Psel = 2'b01;
    cyc(); cyc();
    chk("mis_sticky_pc", PC, 64'h200A);
    chk("mis_sticky", {63'd0, misalign}, 64'd1);

    // Flag latch and hold, with commits
    Psel = 2'b00; SL = 1; alu_flags = 4'b1010; commit = 1;
    cyc(); chk("flags_set", {60'd0, status[4:1]}, 64'b1001);
    SL = 0; alu_flags = 4'b0101;
    cyc(); chk("flags_hold", {60'd0, status[4:1]}, 64'b1001);
    alu_zero = 1; #1;
    chk("zi_live", {63'd0, status[0]}, 64'd1);
    chk("retired_2", {60'd0, retired}, 64'd2);

    // Branch and SL together: PC moves, flags update
    Psel = 2'b01; SL = 1; alu_flags = 4'b0001; commit = 0; alu_zero = 0;
    cyc(); chk("same_cyc_pc", PC, 64'h200E);
    chk("same_cyc_flags", {60'd0, status[4:1]}, 64'b0010);

    // Stall freezes everything
    stall = 1; Psel = 2'b01; SL = 1; alu_flags = 4'b1100; commit = 1;
    cyc(); cyc(); cyc();
    chk("stall_pc", PC, 64'h200E);
    chk("stall_flags", {60'd0, status[4:1]}, 64'b0010);
    chk("stall_retired", {60'd0, retired}, 64'd2);

    // PC wrap via sequential step
    stall = 0; SL = 0; commit = 0;
    Psel = 2'b10; PCsel = 0; data_bus = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(); Psel = 2'b01;
    cyc(); chk("pc_wrap", PC, 64'h0);

    // Retired counter wrap
    Psel = 2'b00; commit = 1;
    for (int i = 0; i < 13; i++) cyc();
    chk("retired_max", {60'd0, retired}, 64'd15);
    cyc(); chk("retired_wrap", {60'd0, retired}, 64'd0);

    // Reset in the middle of a branch
    commit = 0; Psel = 2'b11; PCsel = 1; K = 64'd5; reset = 1;
    cyc(); chk("rst_mid_pc", PC, 64'h0);
    chk("rst_mid_mis", {63'd0, misalign}, 64'd0);
    chk("rst_mid_flags", {60'd0, status[4:1]}, 64'd0);
    reset = 0; Psel = 2'b00;
    cyc(); cyc();

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
